// File: rtl/sopc_mem_pkg.sv
// Shared definitions for the SOPC memory models: FSM encoding, byte-lane geometry
// and wait-state counter sizing.
package sopc_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } mem_state_t;

  localparam int unsigned LANE_W      = 8;
  localparam int unsigned LANE_CNT    = 4;
  localparam int unsigned MAX_LATENCY = 15;
  localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable wait-state down-counter with zero flag; shared by the data RAM and ROM models.
module mem_wait_cnt
  import sopc_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sopc_data_mem.sv
// Multi-cycle req/ack data memory with byte-lane writes and LATENCY wait states.
// Optional SOPC_MEM_BOUNDS_CHECK_EN: flag and suppress out-of-range accesses via err.
module sopc_data_mem
  import sopc_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            byte_slct,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ack,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  mem_state_t state, state_nxt;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       do_access;

  logic             cap_we;
  logic [IDX_W-1:0] cap_idx;
  logic [3:0]       cap_be;
  logic [31:0]      cap_wdata;
  logic             cap_oor;
  logic             addr_unused;

  assign addr_unused = ^addr;

  mem_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_W'(LATENCY)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    do_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          cnt_load  = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          do_access = 1'b1;
          state_nxt = S_ACK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cnt_load) begin
      cap_we    <= we;
      cap_idx   <= addr[IDX_W+1:2];
      cap_be    <= byte_slct;
      cap_wdata <= wdata;
    end
  end

`ifdef SOPC_MEM_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (cnt_load) begin
      cap_oor <= (addr >= ADDR_WIDTH'(DEPTH_WORDS * 4));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= do_access & cap_oor;
    end
  end
`else
  assign cap_oor = 1'b0;
  assign err     = 1'b0;
`endif

  // Reset on the access edge itself still discards the pending write.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANE_CNT; i++) begin
      if (do_access && !rst && cap_we && !cap_oor && cap_be[i]) begin
        mem[cap_idx][i*LANE_W +: LANE_W] <= cap_wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ack   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= do_access;
      if (do_access && !cap_we) begin
        rdata <= cap_oor ? '0 : mem[cap_idx];
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule
